// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch controller: state encoding,
// timeout default, fetch word width and the zero instruction.
package if_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned STALL_W        = 16;
  localparam int unsigned WAIT_LIMIT_DEF = 15;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [XLEN-1:0] INSTR_NOP = '0;

  // Any taken branch or non-zero jump code redirects the PC.
  function automatic logic is_redir(input logic       pcsrc,
                                    input logic [1:0] jump,
                                    input logic [1:0] rjump);
    return pcsrc | (|jump) | (|rjump);
  endfunction

endpackage

// File: rtl/if_wait_timer.sv
// Counts consecutive un-acknowledged request cycles; flags the cycle in which
// the count would reach LIMIT.
module if_wait_timer
  import if_pkg::*;
#(
  parameter int unsigned LIMIT = WAIT_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic ack_i,
  output logic timeout_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || ack_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign timeout_c = req_i && !ack_i && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: issues instruction-memory requests, handles
// stalls, redirects with in-flight discard, and a sticky fetch timeout.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               STALL_ID,
  input  logic               PCSRC,
  input  logic [1:0]         JUMP,
  input  logic [1:0]         RJUMP,
  input  logic [XLEN-1:0]    PC_CUR,
  output logic               IMEM_REQ,
  output logic [XLEN-1:0]    IMEM_ADDR,
  input  logic               IMEM_ACK,
  input  logic [XLEN-1:0]    IMEM_RDATA,
  output logic               PC_WRITE,
  output logic               FLUSH_IF,
  output logic               IF_VALID,
  output logic [XLEN-1:0]    IF_INSTR,
  output logic               FETCH_ERR,
  output logic [STALL_W-1:0] STALL_CNT
);

  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    instr_q, instr_d;
  logic [XLEN-1:0]    hold_q, hold_d;
  logic               issued_q, issued_d;
  logic               drop_q, drop_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               redir_c, pc_write_c, flush_c, timeout_c, in_fetch_c;

  assign redir_c    = is_redir(PCSRC, JUMP, RJUMP);
  assign in_fetch_c = (state_q == ST_FETCH);

  if_wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk_i    (CLOCK),
    .rst_ni   (RESET),
    .req_i    (in_fetch_c),
    .ack_i    (IMEM_ACK),
    .timeout_c(timeout_c)
  );

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    hold_d      = hold_q;
    issued_d    = issued_q;
    drop_d      = drop_q;
    valid_d     = valid_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    pc_write_c  = 1'b0;
    flush_c     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        flush_c    = redir_c;
        pc_write_c = redir_c;
        valid_d    = 1'b0;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        flush_c    = redir_c;
        pc_write_c = redir_c;
        if (!issued_q) begin
          addr_d = PC_CUR;
        end
        if (timeout_c) begin
          state_d  = ST_ERR;
          err_d    = 1'b1;
          valid_d  = 1'b0;
          drop_d   = 1'b0;
          issued_d = 1'b0;
        end else if (IMEM_ACK) begin
          issued_d = 1'b0;
          drop_d   = 1'b0;
          if (redir_c || drop_q) begin
            valid_d = 1'b0;
          end else if (STALL_ID) begin
            hold_d  = IMEM_RDATA;
            state_d = ST_HOLD;
          end else begin
            pc_write_c = 1'b1;
            instr_d    = IMEM_RDATA;
            valid_d    = 1'b1;
          end
        end else begin
          // Request stays up with its latched address; a redirect only marks it stale.
          issued_d = 1'b1;
          valid_d  = 1'b0;
          if (redir_c) begin
            drop_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        flush_c = redir_c;
        if (redir_c) begin
          pc_write_c = 1'b1;
          hold_d     = INSTR_NOP;
          valid_d    = 1'b0;
          state_d    = ST_FETCH;
        end else if (!STALL_ID) begin
          pc_write_c = 1'b1;
          instr_d    = hold_q;
          valid_d    = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase

    if ((state_q == ST_FETCH || state_q == ST_HOLD) && !pc_write_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_BOOT;
      addr_q      <= '0;
      instr_q     <= INSTR_NOP;
      hold_q      <= INSTR_NOP;
      issued_q    <= 1'b0;
      drop_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      hold_q      <= hold_d;
      issued_q    <= issued_d;
      drop_q      <= drop_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // First request cycle presents the live PC; later cycles hold the latched one.
  assign IMEM_REQ  = in_fetch_c;
  assign IMEM_ADDR = (in_fetch_c && !issued_q) ? PC_CUR : addr_q;
  assign PC_WRITE  = pc_write_c & RESET;
  assign FLUSH_IF  = flush_c & RESET;
  assign IF_VALID  = valid_q;
  assign IF_INSTR  = instr_q;
  assign FETCH_ERR = err_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized + directed bench for if_fetch_ctrl: a transaction-level model of
// the fetch pipeline pushes expected per-cycle outputs that a monitor checks.
module tb_if_fetch_ctrl;

  localparam int LIMIT = 15;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL_ID = 1'b0, PCSRC = 1'b0, IMEM_ACK = 1'b0;
  logic [1:0]  JUMP = 2'b00, RJUMP = 2'b00;
  logic [31:0] PC_CUR = '0, IMEM_RDATA = '0;
  logic        IMEM_REQ, PC_WRITE, FLUSH_IF, IF_VALID, FETCH_ERR;
  logic [31:0] IMEM_ADDR, IF_INSTR;
  logic [15:0] STALL_CNT;

  if_fetch_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .STALL_ID(STALL_ID), .PCSRC(PCSRC),
    .JUMP(JUMP), .RJUMP(RJUMP), .PC_CUR(PC_CUR), .IMEM_REQ(IMEM_REQ),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .PC_WRITE(PC_WRITE), .FLUSH_IF(FLUSH_IF), .IF_VALID(IF_VALID),
    .IF_INSTR(IF_INSTR), .FETCH_ERR(FETCH_ERR), .STALL_CNT(STALL_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        pc_write;
    logic        flush;
    logic        valid;
    logic [31:0] instr;
    logic        err;
    logic [15:0] stall;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Model of the fetch pipeline as seen from outside: phase, one pending request, IF/ID latch.
  typedef enum int {M_BOOT, M_FETCH, M_HOLD, M_DEAD} mphase_t;
  mphase_t     ph;
  logic [31:0] pc, pend_addr, held_word, cur_word;
  int          age, lat, stalls;
  bit          doomed, cur_valid, dead_flag;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  always @(negedge CLOCK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("imem_req", 32'(IMEM_REQ), 32'(mon_e.req));
      if (mon_e.req) chk("imem_addr", IMEM_ADDR, mon_e.addr);
      chk("pc_write", 32'(PC_WRITE), 32'(mon_e.pc_write));
      chk("flush_if", 32'(FLUSH_IF), 32'(mon_e.flush));
      chk("if_valid", 32'(IF_VALID), 32'(mon_e.valid));
      chk("if_instr", IF_INSTR, mon_e.instr);
      chk("fetch_err", 32'(FETCH_ERR), 32'(mon_e.err));
      chk("stall_cnt", 32'(STALL_CNT), 32'(mon_e.stall));
    end
  end

  task automatic model_reset();
    ph = M_BOOT; pc = '0; pend_addr = '0; held_word = '0; cur_word = '0;
    age = 0; lat = 0; stalls = 0; doomed = 0; cur_valid = 0; dead_flag = 0;
  endtask

  // Asserts reset mid-cycle with noisy inputs, checks outputs at once, releases after two edges.
  task automatic apply_reset(input string tag);
    RESET = 1'b0; PCSRC = 1'b1; JUMP = 2'b01; RJUMP = 2'b10; STALL_ID = 1'b0;
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hFFFF_FFFF; PC_CUR = 32'h0000_1234;
    #1;
    chk({tag, "_req"}, 32'(IMEM_REQ), 32'd0);
    chk({tag, "_addr"}, IMEM_ADDR, 32'd0);
    chk({tag, "_pcw"}, 32'(PC_WRITE), 32'd0);
    chk({tag, "_flush"}, 32'(FLUSH_IF), 32'd0);
    chk({tag, "_valid"}, 32'(IF_VALID), 32'd0);
    chk({tag, "_instr"}, IF_INSTR, 32'd0);
    chk({tag, "_err"}, 32'(FETCH_ERR), 32'd0);
    chk({tag, "_stall"}, 32'(STALL_CNT), 32'd0);
    repeat (2) @(posedge CLOCK);
    #1;
    PCSRC = 1'b0; JUMP = 2'b00; RJUMP = 2'b00; IMEM_ACK = 1'b0; IMEM_RDATA = '0;
    model_reset();
    RESET = 1'b1;
  endtask

  // One clock: drive inputs, predict this cycle's outputs, advance the model.
  task automatic cycle(input bit stall, input bit pcsrc, input logic [1:0] jump,
                       input logic [1:0] rjump, input bit ack, input logic [31:0] rdata,
                       input logic [31:0] target);
    snap_t   e;
    bit      redir, pw;
    mphase_t nph;
    STALL_ID = stall; PCSRC = pcsrc; JUMP = jump; RJUMP = rjump;
    IMEM_ACK = ack; IMEM_RDATA = rdata; PC_CUR = pc;
    redir   = pcsrc || (jump != 2'b00) || (rjump != 2'b00);
    e.req   = (ph == M_FETCH);
    e.addr  = (age == 0) ? pc : pend_addr;
    e.flush = redir && (ph != M_DEAD);
    e.valid = cur_valid;
    e.instr = cur_word;
    e.err   = dead_flag;
    e.stall = 16'(stalls);
    pw  = 0;
    nph = ph;
    case (ph)
      M_BOOT: begin
        pw = redir; nph = M_FETCH; age = 0;
      end
      M_FETCH: begin
        if (age == 0) pend_addr = pc;
        if (ack) begin
          if (redir || doomed) begin
            pw = redir; cur_valid = 0;
          end else if (stall) begin
            held_word = rdata; nph = M_HOLD;
          end else begin
            pw = 1; cur_word = rdata; cur_valid = 1;
          end
          doomed = 0; age = 0;
        end else begin
          pw = redir; cur_valid = 0;
          if (redir) doomed = 1;
          age++;
          if (age == LIMIT) begin
            nph = M_DEAD; dead_flag = 1;
          end
        end
      end
      M_HOLD: begin
        if (redir) begin
          pw = 1; cur_valid = 0; nph = M_FETCH;
        end else if (!stall) begin
          pw = 1; cur_word = held_word; cur_valid = 1; nph = M_FETCH;
        end
      end
      default: ;
    endcase
    e.pc_write = pw;
    if ((ph == M_FETCH || ph == M_HOLD) && !pw && stalls < 65535) stalls++;
    if (pw) pc = redir ? target : pc + 32'd4;
    ph = nph;
    exp_q.push_back(e);
    @(posedge CLOCK);
    #1;
  endtask

  task automatic quiet(input bit ack, input logic [31:0] rdata);
    cycle(1'b0, 1'b0, 2'b00, 2'b00, ack, rdata, 32'd0);
  endtask

  initial begin
    bit          st, pcs, ak;
    logic [1:0]  j, rj;
    int          r;
    model_reset();
    #2;
    apply_reset("por");

    // Back-to-back zero-wait fetches from PC 0.
    for (int i = 0; i < 12; i++) quiet(1'b1, $urandom);
    chk("zw_valid", 32'(IF_VALID), 32'd1);

    // Three wait cycles before the acknowledge.
    apply_reset("rst_b");
    quiet(1'b0, '0);
    for (int i = 0; i < 3; i++) quiet(1'b0, '0);
    quiet(1'b1, 32'h0000_0013);
    chk("lat3_instr", IF_INSTR, 32'h0000_0013);
    chk("lat3_stall", 32'(STALL_CNT), 32'd3);

    // Acknowledge coincident with an ID stall held for two cycles.
    apply_reset("rst_c");
    quiet(1'b0, '0);
    cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 32'hCAFE_0001, '0);
    cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, '0, '0);
    quiet(1'b0, '0);
    chk("hold_instr", IF_INSTR, 32'hCAFE_0001);
    chk("hold_valid", 32'(IF_VALID), 32'd1);

    // Branch redirect one cycle before a delayed acknowledge; the stale word must vanish.
    apply_reset("rst_d");
    quiet(1'b0, '0);
    quiet(1'b0, '0);
    cycle(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, '0, 32'h0000_0100);
    quiet(1'b1, 32'hDEAD_BEEF);
    chk("redir_drop_valid", 32'(IF_VALID), 32'd0);
    quiet(1'b1, 32'h0000_0011);
    quiet(1'b0, '0);

    // Memory never answers: sticky error, inputs ignored afterwards.
    apply_reset("rst_e");
    quiet(1'b0, '0);
    for (int i = 0; i < LIMIT; i++) quiet(1'b0, '0);
    chk("to_err", 32'(FETCH_ERR), 32'd1);
    chk("to_req", 32'(IMEM_REQ), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b11, 2'b00, 1'b1, 32'h1, 32'h40);

    // Reset in the middle of a pending request.
    apply_reset("rst_f");
    quiet(1'b0, '0);
    quiet(1'b0, '0);
    apply_reset("mid_wait");
    quiet(1'b0, '0);
    quiet(1'b1, 32'h0000_0033);

    // Random traffic: latencies, stalls, branch and jump redirects.
    for (int i = 0; i < 1500; i++) begin
      if (ph == M_FETCH && age == 0) lat = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 5);
      st  = ($urandom_range(0, 3) == 0);
      r   = $urandom_range(0, 15);
      pcs = (r == 0);
      j   = (r == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      rj  = (r == 2) ? 2'($urandom_range(1, 3)) : 2'b00;
      ak  = (ph == M_FETCH) && (age >= lat);
      cycle(st, pcs, j, rj, ak, $urandom, $urandom & 32'hFFFF_FFFC);
    end

    @(negedge CLOCK);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
